hbmc_wr_seq: RTL and testbench
==============================

# hbmc_wr_seq

Write-data sequencer for the HyperBus memory controller write path. It accepts one write command at a time and moves exactly len+1 32-bit data beats from an AXI-style W stream into the write port of the downstream data FIFO. It releases the memory-side command once enough data is staged to prevent underrun, and reports completion after the memory side finishes. Lives in the AXI clock domain, between the AXI slave front-end and the downstream data FIFO / HyperBus transfer engine.

## Interface
- DATA_WIDTH, 32, W beat width; only 32 is legal, matching the FIFO's 36-bit write port.
- LEN_WIDTH, 8, burst length field width (beats minus one).
- ADDR_WIDTH, 32, byte address width.
- PRIME_BEATS, 4, beats pushed before the memory command is released; legal range 1..2^LEN_WIDTH.
- clk  in  1  AXI-domain clock; all logic is rising-edge.
- arstn  in  1  asynchronous active-low reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- s_wvalid / s_wready  in / out  1  W handshake.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte strobes.
- s_wlast  in  1  last beat marker.
- fifo_wr_din  out  DATA_WIDTH  to FIFO write data.
- fifo_wr_strb  out  DATA_WIDTH/8  to FIFO write strobes.
- fifo_wr_ena  out  1  FIFO write enable.
- fifo_wr_full  in  1  FIFO full.
- mem_cmd_valid / mem_cmd_ready  out / in  1  memory command handshake.
- mem_cmd_addr  out  ADDR_WIDTH  latched cmd_addr.
- mem_cmd_words  out  LEN_WIDTH+2  16-bit words to transfer, equal to (len+1)*2.
- mem_done  in  1  single-cycle pulse from the transfer engine when the burst is written.
- done_valid / done_ready  out / in  1  completion handshake.
- done_err  out  1  wlast mismatch occurred in this burst.

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd handshake, latch addr/len, clear beat_cnt and err, go to FILL.
  - FILL: s_wready = !fifo_wr_full. fifo_wr_ena = s_wvalid & s_wready. fifo_wr_din and fifo_wr_strb pass s_wdata and s_wstrb straight through. Each push increments beat_cnt (width LEN_WIDTH+1).
  - PAD: reached on early wlast. Pushes data 0, strobe 0 whenever !fifo_wr_full until beat_cnt reaches len+1. s_wready=0.
  - DISCARD: reached when the final counted beat lacks wlast. s_wready=1, no pushes, until a beat with wlast is accepted.
  - WAIT_MEM: waits for both mem_done and mem_cmd accepted.
  - RESP: done_valid=1 until done_ready, then IDLE.
- FILL exits:
  - Last counted beat pushed with wlast: go to WAIT_MEM.
  - Last counted beat pushed without wlast: set err, go to DISCARD.
  - wlast on a beat before the last count: set err. Go to PAD, or to WAIT_MEM if that beat completed the count.
- DISCARD exits to WAIT_MEM.
- Memory command release: the mem_cmd_pend flag sets on the push that makes beat_cnt == min(PRIME_BEATS, len+1). mem_cmd_valid = mem_cmd_pend and stays high until mem_cmd_ready, independent of state. A sticky issued flag prevents a second release.
- mem_done: sticky capture. A pulse arriving while still in FILL, PAD or DISCARD is retained.
- The memory side always sees exactly len+1 beats; padded beats carry zero strobes and do not modify memory.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after release. All other outputs are 0 and the state is IDLE.
- cmd handshake to first possible s_wready: 1 cycle.
- W beat to fifo_wr_ena: 0 cycles (combinational). Throughput is 1 beat/cycle while not full.
- fifo_wr_full high: s_wready=0 in the same cycle, and nothing is pushed.
- mem_cmd_valid asserts 1 cycle after the priming push.
- mem_done seen (with the command issued and all beats handled) to done_valid: 1 cycle.
- done handshake to cmd_ready: 1 cycle.
- Reset mid-burst: immediate return to IDLE; the partial burst is abandoned. The system asserts fifo_arst in the same window.

## Structure
- Shared package hbmc_wr_seq_pkg holds:
  - the state enum (IDLE, FILL, PAD, DISCARD, WAIT_MEM, RESP);
  - the localparam WORDS_PER_BEAT = DATA_WIDTH/16.
- No sub-module. Counters and flags are inline; a single always block handles the state register.

## Test plan
- cmd_len=3, 4 clean beats with wlast on beat 4, PRIME_BEATS=4 -> 4 pushes; mem_cmd_words=8, valid one cycle after push 4; mem_done -> done_valid=1, done_err=0.
- cmd_len=7, fifo_wr_full held for cycles 2-5 -> s_wready low exactly then; 8 pushes total in order; no push while full.
- cmd_len=3, wlast on beat 2 -> 2 data pushes plus 2 zero-strobe pushes; done_err=1; mem_cmd_words=8.
- cmd_len=1, 4 beats with wlast on beat 4 -> 2 pushes; beats 3-4 accepted and dropped; done_err=1.
- cmd_len=0, PRIME_BEATS=4, mem_done arriving before mem_cmd_ready -> mem command released after 1 beat; done_valid only after both events.
- arstn asserted in FILL after 2 of 8 beats -> all outputs 0 at once; after release, a new cmd_len=0 burst completes normally.

Source files
------------

// File: rtl/hbmc_wr_seq_pkg.sv
// Shared types and constants for the HyperBus write-data sequencer.
// The beat width is fixed at 32 bits to match the 36-bit write port of the data FIFO.
package hbmc_wr_seq_pkg;

    localparam int HBMC_DATA_WIDTH = 32;
    localparam int WORDS_PER_BEAT  = HBMC_DATA_WIDTH / 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        DISCARD,
        WAIT_MEM,
        RESP
    } wr_state_e;

endpackage

// File: rtl/hbmc_wr_seq.sv
// Write-data sequencer: moves len+1 W beats into the data FIFO, releases the memory
// command once the prime threshold is staged, and reports completion after mem_done.
module hbmc_wr_seq
    import hbmc_wr_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = HBMC_DATA_WIDTH,
    parameter int LEN_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int PRIME_BEATS = 4
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    output logic [DATA_WIDTH-1:0]   fifo_wr_din,
    output logic [DATA_WIDTH/8-1:0] fifo_wr_strb,
    output logic                    fifo_wr_ena,
    input  logic                    fifo_wr_full,
    output logic                    mem_cmd_valid,
    input  logic                    mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
    output logic [LEN_WIDTH+1:0]    mem_cmd_words,
    input  logic                    mem_done,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic                    done_err
);

    localparam logic [LEN_WIDTH:0]   ONE_CNT   = (LEN_WIDTH+1)'(1);
    localparam logic [LEN_WIDTH:0]   PRIME_CNT = (LEN_WIDTH+1)'(PRIME_BEATS);
    localparam logic [LEN_WIDTH+1:0] WPB       = (LEN_WIDTH+2)'(WORDS_PER_BEAT);

    wr_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH:0]      target_q, target_d;
    logic [LEN_WIDTH:0]      prime_q, prime_d;
    logic [LEN_WIDTH+1:0]    words_q, words_d;
    logic [LEN_WIDTH:0]      beat_cnt_q, beat_cnt_d;
    logic                    err_q, err_d;
    logic                    pend_q, pend_d;
    logic                    issued_q, issued_d;
    logic                    mem_done_q, mem_done_d;
    logic                    out_of_rst_q;

    logic [LEN_WIDTH:0]      cmd_beats;
    logic [LEN_WIDTH:0]      cnt_inc;
    logic                    push;
    logic                    mem_accept;

    assign cmd_beats     = {1'b0, cmd_len} + ONE_CNT;
    assign cnt_inc       = beat_cnt_q + ONE_CNT;
    assign mem_accept    = pend_q & mem_cmd_ready;
    assign mem_cmd_valid = pend_q;
    assign mem_cmd_addr  = addr_q;
    assign mem_cmd_words = words_q;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        target_d     = target_q;
        prime_d      = prime_q;
        words_d      = words_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        pend_d       = pend_q;
        issued_d     = issued_q;
        mem_done_d   = mem_done_q | (mem_done & (state_q != IDLE));
        cmd_ready    = 1'b0;
        s_wready     = 1'b0;
        fifo_wr_ena  = 1'b0;
        fifo_wr_din  = '0;
        fifo_wr_strb = '0;
        done_valid   = 1'b0;
        done_err     = 1'b0;
        push         = 1'b0;

        if (mem_accept) begin
            pend_d   = 1'b0;
            issued_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Held low until the first clock after reset release.
                cmd_ready = out_of_rst_q;
                if (cmd_valid && out_of_rst_q) begin
                    addr_d     = cmd_addr;
                    target_d   = cmd_beats;
                    prime_d    = (cmd_beats < PRIME_CNT) ? cmd_beats : PRIME_CNT;
                    words_d    = {1'b0, cmd_beats} * WPB;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    pend_d     = 1'b0;
                    issued_d   = 1'b0;
                    mem_done_d = 1'b0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                s_wready     = !fifo_wr_full;
                push         = s_wvalid & !fifo_wr_full;
                fifo_wr_ena  = push;
                fifo_wr_din  = s_wdata;
                fifo_wr_strb = s_wstrb;
                if (push) begin
                    if (cnt_inc == target_q) begin
                        if (s_wlast) begin
                            state_d = WAIT_MEM;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (s_wlast) begin
                        err_d   = 1'b1;
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                // Zero-strobe filler beats keep the memory-side beat count exact.
                push        = !fifo_wr_full;
                fifo_wr_ena = push;
                if (push && (cnt_inc == target_q)) begin
                    state_d = WAIT_MEM;
                end
            end
            DISCARD: begin
                s_wready = 1'b1;
                if (s_wvalid && s_wlast) begin
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if ((mem_done_q || mem_done) && (issued_q || mem_accept)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                done_valid = 1'b1;
                done_err   = err_q;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            beat_cnt_d = cnt_inc;
            if ((cnt_inc == prime_q) && !pend_q && !issued_q) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            target_q     <= '0;
            prime_q      <= '0;
            words_q      <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            pend_q       <= 1'b0;
            issued_q     <= 1'b0;
            mem_done_q   <= 1'b0;
            out_of_rst_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            addr_q       <= addr_d;
            target_q     <= target_d;
            prime_q      <= prime_d;
            words_q      <= words_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            pend_q       <= pend_d;
            issued_q     <= issued_d;
            mem_done_q   <= mem_done_d;
            out_of_rst_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hbmc_wr_seq.sv
// Directed bench for hbmc_wr_seq: clean bursts, back-pressure, early/late wlast,
// early mem_done and mid-burst reset, with FIFO pushes captured and compared in order.
module tb_hbmc_wr_seq;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wlast = 1'b0;
    logic [31:0] fifo_wr_din;
    logic [3:0]  fifo_wr_strb;
    logic        fifo_wr_ena;
    logic        fifo_wr_full = 1'b0;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b0;
    logic [31:0] mem_cmd_addr;
    logic [9:0]  mem_cmd_words;
    logic        mem_done = 1'b0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic        done_err;

    int checks = 0;
    int errors = 0;
    logic [35:0] pushed[$];
    logic [35:0] expq[$];

    hbmc_wr_seq #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (8),
        .ADDR_WIDTH (32),
        .PRIME_BEATS(4)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wlast      (s_wlast),
        .fifo_wr_din  (fifo_wr_din),
        .fifo_wr_strb (fifo_wr_strb),
        .fifo_wr_ena  (fifo_wr_ena),
        .fifo_wr_full (fifo_wr_full),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_words(mem_cmd_words),
        .mem_done     (mem_done),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_err     (done_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples the push about to be taken at the next rising edge, then moves to the next falling edge.
    task automatic tick();
        #1;
        if (fifo_wr_ena === 1'b1) pushed.push_back({fifo_wr_strb, fifo_wr_din});
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        check("cmd_ready_before_cmd", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic last);
        s_wvalid = 1'b1;
        s_wdata  = d;
        s_wstrb  = s;
        s_wlast  = last;
        tick();
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic accept_mem();
        mem_cmd_ready = 1'b1;
        #1;
        check("mem_cmd_valid_at_accept", mem_cmd_valid, 1'b1);
        tick();
        mem_cmd_ready = 1'b0;
        #1;
        check("mem_cmd_valid_after_accept", mem_cmd_valid, 1'b0);
    endtask

    task automatic finish_burst(input logic exp_err);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        #1;
        check("done_valid", done_valid, 1'b1);
        check("done_err", done_err, exp_err);
        check("mem_cmd_valid_in_resp", mem_cmd_valid, 1'b0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        #1;
        check("done_valid_after_hs", done_valid, 1'b0);
        check("cmd_ready_after_done", cmd_ready, 1'b1);
    endtask

    task automatic check_pushes(input string tag);
        check({tag, "_count"}, 64'(pushed.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < pushed.size(); i++)
            check({tag, "_beat"}, pushed[i], expq[i]);
        pushed.delete();
        expq.delete();
    endtask

    initial begin
        int bi;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_s_wready", s_wready, 1'b0);
        check("rst_fifo_wr_ena", fifo_wr_ena, 1'b0);
        check("rst_mem_cmd_valid", mem_cmd_valid, 1'b0);
        check("rst_done_valid", done_valid, 1'b0);
        check("rst_mem_cmd_words", mem_cmd_words, 10'd0);
        tick();
        arstn = 1'b1;
        #1;
        check("cmd_ready_before_first_edge", cmd_ready, 1'b0);
        tick();
        #1;
        check("cmd_ready_first_cycle", cmd_ready, 1'b1);

        // Clean 4-beat burst
        send_cmd(32'h0000_1000, 8'd3);
        for (int i = 0; i < 4; i++) begin
            s_wvalid = 1'b1;
            s_wdata  = 32'hA000_0000 + i;
            s_wstrb  = 4'hF;
            s_wlast  = (i == 3);
            #1;
            check("t1_s_wready", s_wready, 1'b1);
            check("t1_mem_cmd_valid_early", mem_cmd_valid, 1'b0);
            tick();
            expq.push_back({4'hF, 32'hA000_0000 + i});
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        #1;
        check("t1_mem_cmd_valid", mem_cmd_valid, 1'b1);
        check("t1_mem_cmd_words", mem_cmd_words, 10'd8);
        check("t1_mem_cmd_addr", mem_cmd_addr, 32'h0000_1000);
        accept_mem();
        finish_burst(1'b0);
        check_pushes("t1_push");

        // 8 beats with FIFO full in cycles 2..5
        send_cmd(32'h0000_2000, 8'd7);
        bi = 0;
        for (int cyc = 1; cyc <= 30 && bi < 8; cyc++) begin
            fifo_wr_full = (cyc >= 2 && cyc <= 5);
            s_wvalid = 1'b1;
            s_wdata  = 32'hB000_0000 + bi;
            s_wstrb  = 4'hF;
            s_wlast  = (bi == 7);
            #1;
            check("t2_s_wready", s_wready, !fifo_wr_full);
            if (fifo_wr_full) check("t2_no_push_when_full", fifo_wr_ena, 1'b0);
            if (s_wready) begin
                expq.push_back({4'hF, 32'hB000_0000 + bi});
                bi++;
            end
            tick();
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        fifo_wr_full = 1'b0;
        check("t2_all_beats_in_budget", 64'(bi), 64'd8);
        #1;
        check("t2_mem_cmd_words", mem_cmd_words, 10'd16);
        accept_mem();
        finish_burst(1'b0);
        check_pushes("t2_push");

        // Early wlast on beat 2 of 4: two zero-strobe pad beats
        send_cmd(32'h0000_3000, 8'd3);
        beat(32'hC000_0000, 4'h3, 1'b0);
        beat(32'hC000_0001, 4'hC, 1'b1);
        #1;
        check("t3_pad_s_wready", s_wready, 1'b0);
        check("t3_pad_ena", fifo_wr_ena, 1'b1);
        check("t3_pad_din", fifo_wr_din, 32'h0);
        check("t3_pad_strb", fifo_wr_strb, 4'h0);
        check("t3_mem_cmd_valid_early", mem_cmd_valid, 1'b0);
        tick();
        tick();
        #1;
        check("t3_pad_done_ena", fifo_wr_ena, 1'b0);
        check("t3_mem_cmd_valid", mem_cmd_valid, 1'b1);
        check("t3_mem_cmd_words", mem_cmd_words, 10'd8);
        expq.push_back({4'h3, 32'hC000_0000});
        expq.push_back({4'hC, 32'hC000_0001});
        expq.push_back(36'h0);
        expq.push_back(36'h0);
        accept_mem();
        finish_burst(1'b1);
        check_pushes("t3_push");

        // Late wlast: len=1 but 4 beats arrive, beats 3..4 dropped
        send_cmd(32'h0000_4000, 8'd1);
        beat(32'hD000_0000, 4'hF, 1'b0);
        #1;
        check("t4_mem_cmd_valid_early", mem_cmd_valid, 1'b0);
        beat(32'hD000_0001, 4'hF, 1'b0);
        #1;
        check("t4_mem_cmd_valid", mem_cmd_valid, 1'b1);
        check("t4_discard_s_wready", s_wready, 1'b1);
        s_wvalid = 1'b1;
        s_wdata  = 32'hD000_0002;
        #1;
        check("t4_discard_no_push", fifo_wr_ena, 1'b0);
        tick();
        beat(32'hD000_0003, 4'hF, 1'b1);
        #1;
        check("t4_wait_s_wready", s_wready, 1'b0);
        check("t4_mem_cmd_words", mem_cmd_words, 10'd4);
        expq.push_back({4'hF, 32'hD000_0000});
        expq.push_back({4'hF, 32'hD000_0001});
        accept_mem();
        finish_burst(1'b1);
        check_pushes("t4_push");

        // len=0, mem_done before mem_cmd_ready
        send_cmd(32'h0000_5000, 8'd0);
        beat(32'hE000_0000, 4'h5, 1'b1);
        #1;
        check("t5_mem_cmd_valid", mem_cmd_valid, 1'b1);
        check("t5_mem_cmd_words", mem_cmd_words, 10'd2);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        tick();
        #1;
        check("t5_done_valid_wait_cmd", done_valid, 1'b0);
        mem_cmd_ready = 1'b1;
        #1;
        check("t5_done_valid_at_accept", done_valid, 1'b0);
        tick();
        mem_cmd_ready = 1'b0;
        #1;
        check("t5_done_valid", done_valid, 1'b1);
        check("t5_done_err", done_err, 1'b0);
        check("t5_mem_cmd_valid_after", mem_cmd_valid, 1'b0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        #1;
        check("t5_cmd_ready", cmd_ready, 1'b1);
        expq.push_back({4'h5, 32'hE000_0000});
        check_pushes("t5_push");

        // Reset after 2 of 8 beats, then a clean single-beat burst
        send_cmd(32'h0000_6000, 8'd7);
        beat(32'hF000_0000, 4'hF, 1'b0);
        beat(32'hF000_0001, 4'hF, 1'b0);
        arstn = 1'b0;
        #1;
        check("t6_rst_cmd_ready", cmd_ready, 1'b0);
        check("t6_rst_s_wready", s_wready, 1'b0);
        check("t6_rst_fifo_wr_ena", fifo_wr_ena, 1'b0);
        check("t6_rst_mem_cmd_valid", mem_cmd_valid, 1'b0);
        check("t6_rst_mem_cmd_addr", mem_cmd_addr, 32'h0);
        check("t6_rst_mem_cmd_words", mem_cmd_words, 10'd0);
        check("t6_rst_done_valid", done_valid, 1'b0);
        tick();
        arstn = 1'b1;
        tick();
        expq.push_back({4'hF, 32'hF000_0000});
        expq.push_back({4'hF, 32'hF000_0001});
        check_pushes("t6_partial_push");
        send_cmd(32'h0000_7000, 8'd0);
        beat(32'h7777_0000, 4'hF, 1'b1);
        #1;
        check("t6_mem_cmd_valid", mem_cmd_valid, 1'b1);
        check("t6_mem_cmd_words", mem_cmd_words, 10'd2);
        check("t6_mem_cmd_addr", mem_cmd_addr, 32'h0000_7000);
        accept_mem();
        finish_burst(1'b0);
        expq.push_back({4'hF, 32'h7777_0000});
        check_pushes("t6_push");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
